// File: rtl/reg_bank_wr_arbiter.sv
// Arbitrates NREQ requesters onto one registered write port of an NREGS-entry bank. Grants are same-cycle and combinational; the enable, clear and data outputs are registered one cycle later.
// Stall and bank_clr block grants, and pending requests wait. The REGARB_FIXED_PRIO_EN macro replaces round-robin with fixed lowest-index priority.
module reg_bank_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 11
) (
  input  logic               CLK,
  input  logic               clear,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               bank_clr,
  input  logic               stall,
  output logic [NREQ-1:0]    gnt,
  output logic [NREGS-1:0]   reg_en,
  output logic [NREGS-1:0]   reg_clr,
  output logic [DW-1:0]      wr_data,
  output logic               err_oob
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             w_arb_ok;
  logic             w_any;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ri;
  logic [NREQ-1:0]  w_gnt;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [NREGS-1:0] w_en;
  logic             w_oob;
  int               w_idx;

`ifndef REGARB_FIXED_PRIO_EN
  logic [PW-1:0]    r_ptr;
`endif

  // Clear beats both stall and writes; reset suppresses grants outright.
  assign w_arb_ok = !clear && !stall && !bank_clr;

  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_gnt  = '0;
    w_idx  = 0;
    w_ri   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef REGARB_FIXED_PRIO_EN
      w_idx = k;
`else
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
`endif
      w_ri = PW'(w_idx);
      if (w_arb_ok && !w_any && req[w_ri]) begin
        w_any       = 1'b1;
        w_gidx      = w_ri;
        w_gnt[w_ri] = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*DW +: DW];
      end
    end
  end

  // An address that matches no register decodes to an empty enable, which is the out-of-range case.
  always_comb begin
    w_en = '0;
    for (int j = 0; j < NREGS; j++) begin
      w_en[j] = w_any && (w_addr == AW'(j));
    end
  end

  assign w_oob = w_any && (w_en == '0);
  assign gnt   = w_gnt;

  always_ff @(posedge CLK) begin
    if (clear) begin
      reg_en  <= '0;
      reg_clr <= '0;
      wr_data <= '0;
      err_oob <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      reg_en  <= w_en;
      reg_clr <= {NREGS{bank_clr}};
      if (w_any) wr_data <= w_data;
      if (w_oob) err_oob <= 1'b1;
`ifndef REGARB_FIXED_PRIO_EN
      if (w_any) r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Scoreboarded bench for reg_bank_wr_arbiter: an 8-register instance and a 6-register instance for out-of-range writes.
module tb_reg_bank_wr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 11;

  logic              CLK;
  logic              clear;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              bank_clr;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        reg_en;
  logic [7:0]        reg_clr;
  logic [DW-1:0]     wr_data;
  logic              err_oob;
  logic [NREQ-1:0]   gnt6;
  logic [5:0]        reg_en6;
  logic [5:0]        reg_clr6;
  logic [DW-1:0]     wr_data6;
  logic              err_oob6;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]    en;
    logic [7:0]    clr;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  reg_bank_wr_arbiter #(.NREQ(4), .NREGS(8), .AW(3), .DW(11)) u_dut (
    .CLK(CLK), .clear(clear), .req(req), .req_addr(req_addr), .req_data(req_data),
    .bank_clr(bank_clr), .stall(stall), .gnt(gnt), .reg_en(reg_en), .reg_clr(reg_clr),
    .wr_data(wr_data), .err_oob(err_oob)
  );

  reg_bank_wr_arbiter #(.NREQ(4), .NREGS(6), .AW(3), .DW(11)) u_dut6 (
    .CLK(CLK), .clear(clear), .req(req), .req_addr(req_addr), .req_data(req_data),
    .bank_clr(bank_clr), .stall(stall), .gnt(gnt6), .reg_en(reg_en6), .reg_clr(reg_clr6),
    .wr_data(wr_data6), .err_oob(err_oob6)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) begin
      #3;
      checks++;
      if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      tick();
      checks++;
      if (reg_en !== 8'h00 || reg_clr !== 8'h00 || wr_data !== 11'h0 || err_oob !== 1'b0) begin
        failures++;
        $display("FAIL reset_state got en=%h clr=%h d=%h oob=%b exp all zero", reg_en, reg_clr, wr_data, err_oob);
      end
    end
    clear = 1'b0;
    repeat (3) begin
      #3;
      checks++;
      if (gnt !== 4'b0) begin failures++; $display("FAIL idle_gnt got=%b exp=0000", gnt); end
      tick();
      checks++;
      if (reg_en !== 8'h00 || reg_clr !== 8'h00 || wr_data !== 11'h0 || err_oob !== 1'b0) begin
        failures++;
        $display("FAIL idle_state got en=%h clr=%h d=%h oob=%b exp all zero", reg_en, reg_clr, wr_data, err_oob);
      end
    end
  endtask

  task automatic test_single_write();
    set_req(0, 3'd5, 11'h2A5);
    req = 4'b0001;
    #3;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    sbq.push_back('{en: 8'h20, clr: 8'h00, d: 11'h2A5});
    tick();
    req = 4'b0000;
    e = sbq.pop_front();
    checks++;
    if (reg_en !== e.en || wr_data !== e.d) begin
      failures++; $display("FAIL single_issue got en=%h d=%h exp en=%h d=%h", reg_en, wr_data, e.en, e.d);
    end
    #3;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_drop_gnt got=%b exp=0000", gnt); end
    sbq.push_back('{en: 8'h00, clr: 8'h00, d: 11'h2A5});
    tick();
    e = sbq.pop_front();
    checks++;
    if (reg_en !== e.en || wr_data !== e.d) begin
      failures++; $display("FAIL single_one_cycle got en=%h d=%h exp en=%h d=%h", reg_en, wr_data, e.en, e.d);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 11'h100 + DW'(i));
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      #3;
      checks++;
      if (gnt !== (4'b0001 << order[s])) begin
        failures++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", s, gnt, 4'b0001 << order[s]);
      end
      sbq.push_back('{en: 8'h01 << order[s], clr: 8'h00, d: 11'h100 + DW'(order[s])});
      tick();
      e = sbq.pop_front();
      checks++;
      if (reg_en !== e.en || wr_data !== e.d) begin
        failures++; $display("FAIL rr_issue step=%0d got en=%h d=%h exp en=%h d=%h", s, reg_en, wr_data, e.en, e.d);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_clear_stall();
    logic [3:0] g_exp[7]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [3:0] r_in[7]   = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    logic       clr_in[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       st_in[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] en_exp[7] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    logic [DW-1:0] d_exp[7] = '{11'h100, 11'h101, 11'h101, 11'h101, 11'h101, 11'h102, 11'h102};
    for (int s = 0; s < 7; s++) begin
      req = r_in[s]; bank_clr = clr_in[s]; stall = st_in[s];
      #3;
      checks++;
      if (gnt !== g_exp[s]) begin failures++; $display("FAIL clrstall_gnt step=%0d got=%b exp=%b", s, gnt, g_exp[s]); end
      sbq.push_back('{en: en_exp[s], clr: clr_in[s] ? 8'hFF : 8'h00, d: d_exp[s]});
      tick();
      e = sbq.pop_front();
      checks++;
      if (reg_en !== e.en || reg_clr !== e.clr || wr_data !== e.d) begin
        failures++;
        $display("FAIL clrstall_issue step=%0d got en=%h clr=%h d=%h exp en=%h clr=%h d=%h",
                 s, reg_en, reg_clr, wr_data, e.en, e.clr, e.d);
      end
    end
    req = 4'b0000; bank_clr = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (reg_clr !== 8'h00) begin failures++; $display("FAIL clr_one_cycle got=%h exp=00", reg_clr); end
  endtask

  task automatic test_out_of_range();
    checks++;
    if (err_oob6 !== 1'b0) begin failures++; $display("FAIL oob_initial got=%b exp=0", err_oob6); end
    set_req(0, 3'd7, 11'h3C3);
    req = 4'b0001;
    #3;
    checks++;
    if (gnt6 !== 4'b0001) begin failures++; $display("FAIL oob_gnt got=%b exp=0001", gnt6); end
    tick();
    req = 4'b0000;
    checks++;
    if (reg_en6 !== 6'h00 || err_oob6 !== 1'b1 || wr_data6 !== 11'h3C3) begin
      failures++; $display("FAIL oob_issue got en=%h oob=%b d=%h exp en=00 oob=1 d=3c3", reg_en6, err_oob6, wr_data6);
    end
    repeat (3) begin
      tick();
      checks++;
      if (err_oob6 !== 1'b1) begin failures++; $display("FAIL oob_sticky got=%b exp=1", err_oob6); end
    end
    checks++;
    if (err_oob !== 1'b0) begin failures++; $display("FAIL inrange_no_oob got=%b exp=0", err_oob); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (err_oob6 !== 1'b0) begin failures++; $display("FAIL oob_cleared got=%b exp=0", err_oob6); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 11'h100 + DW'(i));
    req = 4'b0100;
    #3;
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
    sbq.push_back('{en: 8'h04, clr: 8'h00, d: 11'h102});
    tick();
    e = sbq.pop_front();
    checks++;
    if (reg_en !== e.en || wr_data !== e.d) begin
      failures++; $display("FAIL mid_issue got en=%h d=%h exp en=%h d=%h", reg_en, wr_data, e.en, e.d);
    end
    clear = 1'b1;
    req = 4'b1111;
    #3;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_clear_gnt got=%b exp=0000", gnt); end
    tick();
    checks++;
    if (reg_en !== 8'h00 || wr_data !== 11'h0) begin
      failures++; $display("FAIL mid_clear_state got en=%h d=%h exp en=00 d=000", reg_en, wr_data);
    end
    clear = 1'b0;
    #3;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_ptr_reset got=%b exp=0001", gnt); end
    sbq.push_back('{en: 8'h01, clr: 8'h00, d: 11'h100});
    tick();
    req = 4'b0000;
    e = sbq.pop_front();
    checks++;
    if (reg_en !== e.en || wr_data !== e.d) begin
      failures++; $display("FAIL mid_after_issue got en=%h d=%h exp en=%h d=%h", reg_en, wr_data, e.en, e.d);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals[3] = '{11'h011, 11'h7FF, 11'h555};
    req = 4'b1000;
    for (int s = 0; s < 3; s++) begin
      set_req(3, 3'd3, vals[s]);
      #3;
      checks++;
      if (gnt !== 4'b1000) begin failures++; $display("FAIL b2b_gnt step=%0d got=%b exp=1000", s, gnt); end
      sbq.push_back('{en: 8'h08, clr: 8'h00, d: vals[s]});
      tick();
      e = sbq.pop_front();
      checks++;
      if (reg_en !== e.en || wr_data !== e.d) begin
        failures++; $display("FAIL b2b_issue step=%0d got en=%h d=%h exp en=%h d=%h", s, reg_en, wr_data, e.en, e.d);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (reg_en !== 8'h00 || wr_data !== 11'h555) begin
      failures++; $display("FAIL b2b_idle got en=%h d=%h exp en=00 d=555", reg_en, wr_data);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clear = 1'b1; req = '0; req_addr = '0; req_data = '0; bank_clr = 1'b0; stall = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear_stall();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
